// File: rtl/scan_mux_if.sv
// Bundle of the scan_mux data-path and handshake signals.
// The producer/consumer side uses the master modport; the mux uses the slave modport.
interface scan_mux_if #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int SW = 4
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ack;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ack, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ack, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/scan_mux.sv
// N-channel capture multiplexer with a single registered output word.
// Fixed mode captures the channel named by sel; scan mode round-robins from ptr.
module scan_mux #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int SW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_mux_if.slave  bus
);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_ch_q,    out_ch_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic          reg_free;
    logic          capture;
    logic [N-1:0]  ack;

    // The output register can take a new word when empty or being drained this cycle.
    assign reg_free = !out_valid_q || bus.out_ready;
    assign capture  = grant_found && reg_free;

    // Grant selection: fixed sel, or first valid channel searching upward from ptr.
    always_comb begin : grant_sel
        int c;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        c           = 0;
        if (!bus.mode) begin
            // sel values with no matching channel (sel >= N) simply never match.
            for (int k = 0; k < N; k++) begin
                if (bus.sel == SW'(k) && bus.in_valid[k]) begin
                    grant_found = 1'b1;
                    grant_idx   = SW'(k);
                end
            end
        end else begin
            // Walk the search order backwards so the last hit is the earliest in order.
            for (int i = N - 1; i >= 0; i--) begin
                c = int'(ptr_q) + i;
                if (c >= N) c = c - N;
                if (bus.in_valid[c]) begin
                    grant_found = 1'b1;
                    grant_idx   = SW'(c);
                end
            end
        end
    end

    // Data multiplexer for the granted channel.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SW'(k)) grant_data = bus.in_data[k*W +: W];
        end
    end

    // One-hot acknowledge; held low while reset is asserted.
    always_comb begin
        ack = '0;
        if (capture && rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (grant_idx == SW'(k)) ack[k] = 1'b1;
            end
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            if (bus.mode) begin
                ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (bus.out_ready) begin
            // Word drained with nothing to replace it; data and channel keep their values.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset clears everything immediately, discarding any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset too, since it is a visible output that must read zero in reset.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ack    = ack;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed table, corner sequences, randomized model check.
module tb_scan_mux;

    localparam int N = 16;
    localparam int W = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    scan_mux_if #(.N(N), .W(W), .SW(SW)) bus ();
    scan_mux_if #(.N(12), .W(W), .SW(4)) bus12 ();

    scan_mux #(.N(N), .W(W), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    scan_mux #(.N(12), .W(W), .SW(4)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] valid;
        logic        ready;
        logic [15:0] ack;
        logic        ov;
        logic [7:0]  od;
        logic [3:0]  och;
    } vec_t;

    vec_t tbl[8];

    // Behavioural model state
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pattern_data();
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 8'hA0 + 8'(k);
    endtask

    // Apply inputs, check combinational ack mid-cycle, then registered outputs after the edge.
    task automatic vstep(input logic m, input logic [3:0] s, input logic [15:0] v, input logic r,
                         input logic [15:0] ea, input logic eov, input logic [7:0] eod,
                         input logic [3:0] eoch, input string nm);
        bus.mode = m;
        bus.sel = s;
        bus.in_valid = v;
        bus.out_ready = r;
        @(negedge clk);
        check({nm, "_ack"}, 32'(bus.in_ack), 32'(ea));
        @(posedge clk);
        #1;
        check({nm, "_ov"}, 32'(bus.out_valid), 32'(eov));
        check({nm, "_od"}, 32'(bus.out_data), 32'(eod));
        check({nm, "_och"}, 32'(bus.out_ch), 32'(eoch));
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        bus12.in_valid = '0;
        rst_n = 1'b0;
        #3;
        check("rst_ov", 32'(bus.out_valid), 32'h0);
        check("rst_od", 32'(bus.out_data), 32'h0);
        check("rst_och", 32'(bus.out_ch), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_data = '0;
        m_ch = 0;
        m_ptr = 0;
    endtask

    // Reference grant: spec search rules expressed with modular arithmetic.
    function automatic int model_grant(input logic m, input int s, input logic [15:0] v, input int ptr);
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic random_step();
        int g;
        logic free;
        logic [15:0] exp_ack;
        logic [7:0] gdata;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 8'($urandom);
        bus.in_valid = 16'($urandom & $urandom);
        bus.mode = 1'($urandom);
        bus.sel = 4'($urandom_range(0, 15));
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        g = model_grant(bus.mode, int'(bus.sel), bus.in_valid, m_ptr);
        free = !m_valid || bus.out_ready;
        exp_ack = (g >= 0 && free) ? (16'h1 << g) : 16'h0;
        check("rnd_ack", 32'(bus.in_ack), 32'(exp_ack));
        gdata = (g >= 0) ? bus.in_data[g*W +: W] : 8'h0;
        @(posedge clk);
        if (g >= 0 && free) begin
            m_valid = 1'b1;
            m_data = gdata;
            m_ch = g;
            if (bus.mode) m_ptr = (g + 1) % N;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("rnd_ov", 32'(bus.out_valid), 32'(m_valid));
        check("rnd_od", 32'(bus.out_data), 32'(m_data));
        check("rnd_och", 32'(bus.out_ch), 32'(m_ch));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        bus12.mode = 1'b0; bus12.sel = '0; bus12.in_valid = '0; bus12.out_ready = 1'b0;
        bus12.in_data = '0;
        set_pattern_data();

        // Reset state with traffic offered: no ack while held in reset.
        bus.in_valid = 16'hFFFF;
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        #12;
        check("rst_ack", 32'(bus.in_ack), 32'h0);
        do_reset();

        // Table: fixed capture, bad sel drain, ptr untouched by fixed mode, stall, wrap.
        tbl[0] = '{1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 8'hA5, 4'd5};
        tbl[1] = '{1'b0, 4'd15, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 8'hA5, 4'd5};
        tbl[2] = '{1'b0, 4'd15, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'hA5, 4'd5};
        tbl[3] = '{1'b1, 4'd0,  16'h0003, 1'b1, 16'h0001, 1'b1, 8'hA0, 4'd0};
        tbl[4] = '{1'b1, 4'd0,  16'h0003, 1'b0, 16'h0000, 1'b1, 8'hA0, 4'd0};
        tbl[5] = '{1'b1, 4'd0,  16'h0003, 1'b1, 16'h0002, 1'b1, 8'hA1, 4'd1};
        tbl[6] = '{1'b1, 4'd0,  16'h0001, 1'b1, 16'h0001, 1'b1, 8'hA0, 4'd0};
        tbl[7] = '{1'b0, 4'd3,  16'h0000, 1'b1, 16'h0000, 1'b0, 8'hA0, 4'd0};
        for (int i = 0; i < 8; i++) begin
            vstep(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ready,
                  tbl[i].ack, tbl[i].ov, tbl[i].od, tbl[i].och, $sformatf("tbl%0d", i));
        end

        // Full scan: 17 back-to-back captures 0..15,0.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            vstep(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h1 << (i % 16), 1'b1,
                  8'hA0 + 8'(i % 16), 4'(i % 16), $sformatf("scan%0d", i));
        end

        // Stall with ch3 held, ch7 waiting; ch7 taken on the release edge.
        do_reset();
        vstep(1'b0, 4'd3, 16'h0008, 1'b1, 16'h0008, 1'b1, 8'hA3, 4'd3, "stall_cap");
        for (int i = 0; i < 4; i++) begin
            vstep(1'b0, 4'd7, 16'h0080, 1'b0, 16'h0000, 1'b1, 8'hA3, 4'd3, $sformatf("stall%0d", i));
        end
        vstep(1'b0, 4'd7, 16'h0080, 1'b1, 16'h0080, 1'b1, 8'hA7, 4'd7, "stall_rel");

        // Scan wrap from ptr=14.
        do_reset();
        vstep(1'b1, 4'd0, 16'h2000, 1'b1, 16'h2000, 1'b1, 8'hAD, 4'd13, "wrap_p14");
        vstep(1'b1, 4'd0, 16'h0003, 1'b1, 16'h0001, 1'b1, 8'hA0, 4'd0, "wrap_g0");
        vstep(1'b1, 4'd0, 16'h0003, 1'b1, 16'h0002, 1'b1, 8'hA1, 4'd1, "wrap_g1");

        // Fixed sel=15 with ch15 idle.
        do_reset();
        vstep(1'b0, 4'd15, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 8'h00, 4'd0, "sel15");

        // N=12 instance: sel=13 grants nothing; sel=11 works.
        for (int k = 0; k < 12; k++) bus12.in_data[k*W +: W] = 8'h50 + 8'(k);
        bus12.mode = 1'b0; bus12.sel = 4'd13; bus12.in_valid = 12'hFFF; bus12.out_ready = 1'b1;
        @(negedge clk);
        check("n12_ack", 32'(bus12.in_ack), 32'h0);
        @(posedge clk); #1;
        check("n12_ov", 32'(bus12.out_valid), 32'h0);
        bus12.sel = 4'd11;
        @(negedge clk);
        check("n12s11_ack", 32'(bus12.in_ack), 32'h800);
        @(posedge clk); #1;
        check("n12s11_ov", 32'(bus12.out_valid), 32'h1);
        check("n12s11_od", 32'(bus12.out_data), 32'h5B);
        check("n12s11_och", 32'(bus12.out_ch), 32'd11);
        bus12.in_valid = '0;

        // Mid-cycle reset while holding a word; ptr must return to 0.
        vstep(1'b1, 4'd0, 16'h0020, 1'b1, 16'h0020, 1'b1, 8'hA5, 4'd5, "arst_pre");
        bus.in_valid = 16'hFFFF;
        bus.out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(bus.out_valid), 32'h0);
        check("arst_od", 32'(bus.out_data), 32'h0);
        check("arst_och", 32'(bus.out_ch), 32'h0);
        check("arst_ack", 32'(bus.in_ack), 32'h0);
        #1;
        rst_n = 1'b1;
        vstep(1'b1, 4'd0, 16'h8001, 1'b1, 16'h0001, 1'b1, 8'hA0, 4'd0, "arst_post");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) random_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N, default 16: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..32.
REQ-003 Parameter SW, default 4: select/channel-index width, equal to ceil(log2(N)); it SHALL be set to at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 in_valid  input  N  per-channel request; bit k high means channel k data is offered.
REQ-008 in_ack  output  N  one-hot pulse; bit k high in the cycle channel k is captured.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-010 sel  input  SW  channel index used in fixed mode; ignored in scan mode.
REQ-011 out_valid  output  1  out_data/out_ch hold a captured word.
REQ-012 out_ready  input  1  consumer accepts the word in a cycle where out_valid is high.
REQ-013 out_data  output  W  registered captured word.
REQ-014 out_ch  output  SW  registered index of the channel that supplied out_data.

Function
REQ-015 The output register SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 In fixed mode, the grant SHALL be channel sel when sel<N and in_valid[sel]=1; otherwise there is no grant.
REQ-017 In scan mode, the grant SHALL be the first channel k with in_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; with no valid channel there is no grant.
REQ-018 On a grant while the register is free: at the next edge, out_data <= in_data[grant], out_ch <= grant and out_valid <= 1.
REQ-019 Latency from capture edge to out_valid SHALL be exactly 1 cycle.
REQ-020 Back-to-back capture SHALL be possible every cycle while out_ready=1.
REQ-021 in_ack SHALL be combinational: in_ack[grant]=1 only in a cycle where a grant exists and the register is free; all other bits SHALL be 0.
REQ-022 A producer SHALL treat its word as consumed only on in_ack; in_valid may be held across stalls without duplicate capture.
REQ-023 When out_valid=1 and out_ready=0: out_data, out_ch and out_valid SHALL hold, and in_ack SHALL be all zero.
REQ-024 When out_valid=1, out_ready=1 and there is no grant: out_valid <= 0 at the next edge; out_data and out_ch SHALL hold their last values.
REQ-025 Round-robin pointer ptr (SW bits): on each capture in scan mode, ptr <= grant+1, wrapping from N-1 to 0.
REQ-026 ptr SHALL not change on fixed-mode captures, on stalls, or on mode changes.
REQ-027 mode and sel SHALL be sampled every cycle; a change SHALL affect only grants in that cycle and later, never a word already in the output register.
REQ-028 A fixed-mode sel>=N SHALL produce no grant, no in_ack and no state change.

Reset
REQ-029 While rst_n=0, regardless of clk: out_valid=0, out_data=0, out_ch=0 and ptr=0; in_ack SHALL be 0 during reset.
REQ-030 Reset asserted mid-transfer SHALL discard the held word immediately; the first capture after deassertion SHALL follow REQ-016/017 with ptr=0.

Verification (N=16, W=8)
REQ-031 Fixed mode: sel=5, in_valid=16'h0020, ch5 data=8'hA5, out_ready=1 -> in_ack=16'h0020 that cycle; next cycle out_valid=1, out_data=A5, out_ch=5.
REQ-032 Scan mode: ptr=0, in_valid=16'hFFFF, all channels ready, out_ready=1 for 17 cycles -> out_ch sequence is 0,1,...,15,0 with one capture per cycle.
REQ-033 Stall: word from ch3 held and out_ready=0 for 4 cycles with in_valid[7]=1 -> out_data/out_ch stay 3's, in_ack=0; on release, ch7 is captured on the same edge that ch3 is accepted.
REQ-034 Scan wrap: ptr=14, in_valid=16'h0003 -> grant ch0 (in_ack=16'h0001), then ptr=1 and the next grant is ch1.
REQ-035 Fixed mode with sel=15 and in_valid[15]=0, and with N=12 and sel=13 -> no in_ack, out_valid stays 0.
REQ-036 rst_n pulsed low between clock edges while out_valid=1 -> outputs zero immediately; after release, scan mode with in_valid=16'h8001 grants ch0 first.
